// File: rtl/step_record_player_if.sv
// rtl/step_record_player_if.sv - FIFO read-side bundle between command FIFO and record player
interface step_record_player_if #(
  parameter int WORD_SIZE = 8
) ();
  logic                 fifo_empty;
  logic [WORD_SIZE-1:0] fifo_data;
  logic                 fifo_read_en;

  // FIFO side: supplies empty flag and read data, receives the pop strobe
  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_en
  );

  // Player side: consumes bytes one pop at a time
  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_en
  );
endinterface

// File: rtl/step_record_player.sv
// rtl/step_record_player.sv - replays 4-byte motion records as step/dir pulse bursts (optional abort input: STEP_ABORT_EN)
module step_record_player #(
  parameter int WORD_SIZE = 8,
  parameter int AXES      = 4,
  parameter int PRESCALE  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef STEP_ABORT_EN
  input  logic                 abort,
`endif
  step_record_player_if.slave  fifo,
  output logic [AXES-1:0]      step,
  output logic [AXES-1:0]      dir,
  output logic                 busy,
  output logic                 underrun,
  output logic [7:0]           records_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_RELOAD = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, CAP, LOAD, RUN_LO, RUN_HI, DONE
  } state_t;

  state_t                   state;
  logic [1:0]               idx;
  logic [WORD_SIZE-1:0]     rec [4];
  logic [2*WORD_SIZE-1:0]   count;
  logic [WORD_SIZE-1:0]     half;
  logic [PW-1:0]            presc;

  // Record fields are read straight from the captured bytes; they stay
  // stable from LOAD until the next fetch overwrites them.
  logic [WORD_SIZE-1:0]     h_eff;
  logic [AXES-1:0]          mask;
  logic                     tick;

  assign h_eff = (rec[3] == '0) ? WORD_SIZE'(1) : rec[3];
  assign mask  = rec[0][AXES-1:0];
  assign tick  = (presc == '0);

  // Pop is decoded from REQ so the byte is on fifo_data during the CAP cycle.
  assign fifo.fifo_read_en = (state == REQ) && !fifo.fifo_empty;

  // Record fetch, timing and pulse generation state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      for (int i = 0; i < 4; i++) rec[i] <= '0;
      count        <= '0;
      half         <= '0;
      presc        <= '0;
      step         <= '0;
      dir          <= '0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      records_done <= '0;
    end else begin
`ifdef STEP_ABORT_EN
      if (abort && state != IDLE) begin
        state <= IDLE;
        step  <= '0;
        busy  <= 1'b0;
      end else begin
`else
      begin
`endif
        case (state)
          IDLE: begin
            if (!fifo.fifo_empty) begin
              state <= REQ;
              idx   <= '0;
              busy  <= 1'b1;
            end
          end
          REQ: begin
            if (!fifo.fifo_empty) begin
              state <= CAP;
            end else if (idx != 2'd0) begin
              underrun <= 1'b1;
            end
          end
          CAP: begin
            rec[idx] <= fifo.fifo_data;
            if (idx == 2'd3) begin
              state <= LOAD;
            end else begin
              idx   <= idx + 2'd1;
              state <= REQ;
            end
          end
          LOAD: begin
            dir   <= rec[0][4 +: AXES];
            count <= {rec[2], rec[1]};
            half  <= h_eff;
            presc <= PRE_RELOAD;
            state <= ({rec[2], rec[1]} == '0) ? DONE : RUN_LO;
          end
          RUN_LO, RUN_HI: begin
            presc <= tick ? PRE_RELOAD : presc - PW'(1);
            if (tick) begin
              if (half == WORD_SIZE'(1)) begin
                half <= h_eff;
                if (state == RUN_LO) begin
                  state <= RUN_HI;
                  step  <= mask;
                end else begin
                  step  <= '0;
                  count <= count - 1'b1;
                  state <= (count == (2*WORD_SIZE)'(1)) ? DONE : RUN_LO;
                end
              end else begin
                half <= half - WORD_SIZE'(1);
              end
            end
          end
          DONE: begin
            records_done <= records_done + 8'd1;
            busy         <= 1'b0;
            step         <= '0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_record_player.sv
// tb/tb_step_record_player.sv - randomized record replay against a waveform-level reference model
module tb_step_record_player;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] step;
  logic [3:0] dir;
  logic       busy;
  logic       underrun;
  logic [7:0] records_done;
`ifdef STEP_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  step_record_player_if #(.WORD_SIZE(8)) fifo_if ();

  step_record_player #(.WORD_SIZE(8), .AXES(4), .PRESCALE(P)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef STEP_ABORT_EN
    .abort        (abort),
`endif
    .fifo         (fifo_if),
    .step         (step),
    .dir          (dir),
    .busy         (busy),
    .underrun     (underrun),
    .records_done (records_done)
  );

  // FIFO model
  logic [7:0] fifo_q [$];
  logic       hold = 1'b0;
  logic       empty_r = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  int         rd_count = 0;

  assign fifo_if.fifo_empty = empty_r;
  assign fifo_if.fifo_data  = fifo_rdata;

  int checks = 0;
  int passes = 0;
  int exp_done = 0;
  logic [3:0] cur_dir = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    if (fifo_if.fifo_read_en) begin
      check("pop_while_empty", {31'b0, empty_r}, 32'd0);
      if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
      rd_count++;
    end
  end

  always @(negedge clk) empty_r = hold || (fifo_q.size() == 0);

  task automatic push_rec(input logic [31:0] r);
    fifo_q.push_back(r[7:0]);
    fifo_q.push_back(r[15:8]);
    fifo_q.push_back(r[23:16]);
    fifo_q.push_back(r[31:24]);
  endtask

  // Builds the expected per-cycle {step,busy,dir} waveform from the record
  // rules: 8 fetch cycles + 1 load, count pulses of (low H*P, high H*P),
  // one completion cycle, then one idle cycle before the next record.
  task automatic run_batch(input int n, input bit spec_first);
    logic [31:0] recs [$];
    logic [8:0]  trace [$];
    logic [3:0]  d;
    int          rd0, w, f0;
    if (spec_first) begin
      recs.push_back(32'h02_00_03_31);
      recs.push_back(32'h05_00_00_0F);
    end
    for (int k = 0; k < n; k++)
      recs.push_back({8'($urandom_range(0, 3)), 8'h00, 8'($urandom_range(0, 3)), 8'($urandom)});
    d = cur_dir;
    foreach (recs[k]) begin
      int c, h, hp;
      logic [7:0] b0;
      b0 = recs[k][7:0];
      c  = int'(recs[k][23:8]);
      h  = int'(recs[k][31:24]);
      if (h == 0) h = 1;
      hp = h * P;
      repeat (9) trace.push_back({4'h0, 1'b1, d});
      d = b0[7:4];
      for (int p = 0; p < c; p++) begin
        repeat (hp) trace.push_back({4'h0, 1'b1, d});
        repeat (hp) trace.push_back({b0[3:0], 1'b1, d});
      end
      trace.push_back({4'h0, 1'b1, d});
      trace.push_back({4'h0, 1'b0, d});
    end
    rd0 = rd_count;
    @(negedge clk);
    #1;
    foreach (recs[k]) push_rec(recs[k]);
    w = 0;
    @(negedge clk);
    while (!busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("batch_start", {31'b0, busy}, 32'd1);
    if (busy) begin
      for (int i = 0; i < trace.size(); i++) begin
        if (i > 0) @(negedge clk);
        f0 = checks - passes;
        check("trace", {23'b0, step, busy, dir}, {23'b0, trace[i]});
        if (checks - passes != f0) break;
      end
    end
    exp_done += recs.size();
    check("records_done", {24'b0, records_done}, {24'b0, 8'(exp_done)});
    check("pop_count", 32'(rd_count - rd0), 32'(4 * recs.size()));
    check("no_underrun", {31'b0, underrun}, 32'd0);
    cur_dir = d;
  endtask

  initial begin
    int w, rd0, rises;
    logic [3:0] prev;

    repeat (3) @(negedge clk);
    check("rst_step", {28'b0, step}, 32'd0);
    check("rst_dir", {28'b0, dir}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_underrun", {31'b0, underrun}, 32'd0);
    check("rst_records_done", {24'b0, records_done}, 32'd0);
    check("rst_read_en", {31'b0, fifo_if.fifo_read_en}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_batch(6, 1'b1);
    run_batch(6, 1'b0);

    // Underrun: only two bytes available, then a long stall
    rd0 = rd_count;
    @(negedge clk);
    #1;
    fifo_q.push_back(8'h12);
    fifo_q.push_back(8'h01);
    repeat (26) @(negedge clk);
    check("stall_pops", 32'(rd_count - rd0), 32'd2);
    check("stall_underrun", {31'b0, underrun}, 32'd1);
    check("stall_busy", {31'b0, busy}, 32'd1);
    #1;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h01);
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("resume_busy_fall", {31'b0, busy}, 32'd0);
    exp_done++;
    check("resume_records_done", {24'b0, records_done}, {24'b0, 8'(exp_done)});
    check("underrun_sticky", {31'b0, underrun}, 32'd1);
    check("resume_dir", {28'b0, dir}, 32'd1);
    cur_dir = 4'h1;

`ifdef STEP_ABORT_EN
    // Abort during the second high phase of a count=4 record
    @(negedge clk);
    #1;
    push_rec(32'h01_00_04_21);
    rises = 0;
    prev = 4'h0;
    w = 0;
    while (rises < 2 && w < 300) begin
      @(negedge clk);
      if (step != 4'h0 && prev == 4'h0) rises++;
      prev = step;
      w++;
    end
    check("abort_reach_hi2", 32'(rises), 32'd2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_step", {28'b0, step}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_records_done", {24'b0, records_done}, {24'b0, 8'(exp_done)});
    check("abort_dir_hold", {28'b0, dir}, 32'd2);
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle_busy", {31'b0, busy}, 32'd0);
    cur_dir = 4'h2;
`endif

    // Asynchronous reset while in a high phase with count=5 remaining
    @(negedge clk);
    #1;
    push_rec(32'h02_00_05_5F);
    w = 0;
    @(negedge clk);
    while (step == 4'h0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("reset_reach_hi", {28'b0, step}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_step", {28'b0, step}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_records_done", {24'b0, records_done}, 32'd0);
    check("async_rst_dir", {28'b0, dir}, 32'd0);
    check("async_rst_underrun", {31'b0, underrun}, 32'd0);
    fifo_q.delete();
    exp_done = 0;
    cur_dir = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_batch(3, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/step_record_player.md
Name: step_record_player

Overview:
- Downstream consumer of the SPI command FIFO.
- Pops 4-byte motion records one byte at a time and replays each as a burst of step pulses on up to AXES stepper channels, with fixed direction bits and pulse period.
- Drives the board's step/dir pins (p1..p8 with AXES=4), sitting between the FIFO read side and the pins.

Parameters:
- WORD_SIZE, 8: FIFO word width in bits.
- AXES, 4: number of step/dir channel pairs; the record format requires AXES ≤ 4.
- PRESCALE, 4: clk cycles per timing tick; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WORD_SIZE  FIFO read data; valid the cycle after fifo_read_en.
- fifo_read_en  out  1  single-cycle pop strobe.
- step  out  AXES  step pulses.
- dir  out  AXES  direction levels.
- busy  out  1  high from the first byte pop until the record completes.
- underrun  out  1  sticky; set if the FIFO is empty mid-record.
- records_done  out  8  completed-record counter; wraps 255→0.

Behaviour:
- Reset (async assert, sync-deassert use assumed by the integrator):
  - State goes to IDLE.
  - All outputs are 0, and the internal count, half-period and prescaler registers are cleared.
- Record format, byte0 popped first:
  - byte0[3:0] is the axis enable mask; byte0[7:4] is dir.
  - byte1 is count[7:0] and byte2 is count[15:8].
  - byte3 is half-period H in ticks; H=0 is treated as 1.
- State REQ:
  - If fifo_empty=0, assert fifo_read_en for exactly 1 cycle and go to CAP.
  - Otherwise stay in REQ with fifo_read_en=0.
  - If byte index > 0 and the FIFO is empty, set underrun.
- State CAP:
  - Latch fifo_data into the byte slot given by the index.
  - Index < 3: increment the index and return to REQ.
  - Index = 3: go to LOAD.
  - A record therefore takes ≥ 8 cycles to fetch.
- IDLE → REQ:
  - Transition when fifo_empty=0, with index=0 and busy set in the same cycle.
  - fifo_read_en is never asserted while fifo_empty=1.
- State LOAD (1 cycle):
  - dir ← byte0[7:4] (low AXES bits).
  - Load count, the half counter ← H, and the prescaler ← PRESCALE-1.
  - If count=0, go to DONE; otherwise go to RUN_LO.
- RUN_LO / RUN_HI:
  - The prescaler counts down each clk; at 0 it reloads and issues a tick.
  - Each tick decrements the half counter. When the half counter is at 1 on a tick, reload it to H and toggle phase.
  - Each phase lasts exactly H·PRESCALE clk cycles.
  - step = mask in RUN_HI, 0 otherwise.
  - Leaving RUN_HI decrements count. If the new count is 0, go to DONE; otherwise go to RUN_LO.
- Dir setup:
  - RUN always begins with a full low phase, so dir leads the first rising step edge by ≥ H·PRESCALE cycles.
  - dir holds until the next LOAD.
- DONE (1 cycle):
  - records_done increments, busy clears and step=0, then go to IDLE.
  - Back-to-back records: IDLE may start REQ on the very next cycle.
- Step period is 2·H·PRESCALE clk cycles. Mask=0 with count>0 still takes full time, producing a silent delay.
- underrun:
  - Cleared only by reset.
  - Fetch resumes when data arrives and is not aborted.
- Reset mid-record: all outputs drop asynchronously. Partially fetched bytes are lost, with no re-sync to a record boundary.

Optional Feature:
- Macro: STEP_ABORT_EN.
- When defined, adds an input port abort (1 bit, synchronous, level).
- abort=1 in any state except IDLE:
  - On the next edge, step goes to 0 and the state goes to IDLE.
  - busy clears and records_done is not incremented.
  - Any popped record bytes are discarded; dir holds its value.
- Abort during REQ/CAP leaves the FIFO byte pointer mid-record; the host is responsible for flushing.
- abort is ignored in IDLE.
- When not defined, there is no abort port and the behaviour above is unchanged.

Test Plan:
- Record {0x31,0x03,0x00,0x02}, PRESCALE=4 → dir=0x3 and step[0] pulses 3 times, each high 8 and low 8 clk; records_done=1; busy falls after the 3rd high phase plus 1 cycle.
- Count=0 record {0x0F,0x00,0x00,0x05} → no step activity, dir=0x0, records_done increments, fifo_read_en pulses exactly 4 times.
- Two queued records with FIFO pre-filled → the second fetch starts 1 cycle after DONE; counts and dir switch only between records; records_done=2.
- Hold fifo_empty=1 after 2 bytes for 20 cycles → fifo_read_en stays 0 and underrun=1; resume → record completes normally.
- Assert rst_n=0 in RUN_HI with count=5 remaining → step, busy and records_done go to 0 immediately without waiting for a clk edge.
- With STEP_ABORT_EN: abort during the 2nd high phase of a count=4 record → step=0 next edge, busy=0, records_done unchanged.
